// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   Read-side consumer of a synchronous FIFO. When transmission is enabled and
//   the FIFO holds data, the block pops one word with a single-cycle read
//   strobe. It captures the word from the FIFO's registered data output on the
//   following cycle. It then shifts the word out as an asynchronous serial
//   frame: one start bit (low), DATA_W data bits LSB first, and STOP_BITS stop
//   bits (high). Every bit is held for CLKS_PER_BIT clock cycles.
//
//   Frame sequence: IDLE -> FETCH -> LOAD -> START -> DATA -> STOP.
//   On the last stop cycle the block either chains straight into the next
//   FETCH or returns to IDLE. A back-to-back frame period is therefore
//   (1 + DATA_W + STOP_BITS) * CLKS_PER_BIT + 2 cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   DATA_W        data bits per frame, equal to the FIFO word width
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  FIFO read strobe, one cycle per word
//   tx_enable   in   permits starting new frames
//   tx          out  serial line, idle high
//   busy        out  high whenever the FSM is not in IDLE
//   byte_done   out  one-cycle pulse on the final stop-bit cycle
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic              tx_enable,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  // Elaboration-time guard against illegal parameterisations.
  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end
    if (DATA_W < 1) begin : g_bad_data
      $error("fifo_uart_tx: DATA_W must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [BAUD_W-1:0]   baud_q;
  logic [BAUD_W-1:0]   baud_nxt;
  logic [BIT_W-1:0]    bit_q;
  logic [BIT_W-1:0]    bit_nxt;
  logic [DATA_W-1:0]   shift_q;
  logic [DATA_W-1:0]   shift_nxt;

  logic                tx_nxt;
  logic                rd_en_nxt;
  logic                busy_nxt;
  logic                byte_done_nxt;

  logic                bit_end;
  logic                start_ok;

  assign bit_end  = (baud_q == BAUD_LAST);
  // Only looked at in IDLE and on the last stop cycle, so a frame in flight
  // never depends on the FIFO flags.
  assign start_ok = tx_enable & ~fifo_empty;

  // State register, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      baud_q     <= baud_nxt;
      bit_q      <= bit_nxt;
      tx         <= tx_nxt;
      fifo_rd_en <= rd_en_nxt;
      busy       <= busy_nxt;
      byte_done  <= byte_done_nxt;
    end
  end

  // Shift register is pure datapath: no reset. A word popped before a reset
  // is simply abandoned; LOAD always overwrites it before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_nxt;
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt = state_q;
    baud_nxt  = baud_q;
    bit_nxt   = bit_q;
    shift_nxt = shift_q;

    case (state_q)
      S_IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
        if (start_ok) begin
          state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        state_nxt = S_LOAD;
      end

      // FIFO data_out is registered, so the word popped in FETCH is
      // present on fifo_data during this cycle.
      S_LOAD: begin
        shift_nxt = fifo_data;
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = S_START;
      end

      S_START: begin
        if (bit_end) begin
          baud_nxt  = '0;
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_nxt  = '0;
          shift_nxt = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = S_STOP;
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end else begin
          baud_nxt = baud_q + 1'b1;
        end
      end

      // bit_q is reused to count stop bits.
      S_STOP: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_q == STOP_LAST) begin
            bit_nxt   = '0;
            state_nxt = start_ok ? S_FETCH : S_IDLE;
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end else begin
          baud_nxt = baud_q + 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next-state values; registering the result keeps
  // every output glitch-free while staying aligned with the state it names.
  always_comb begin
    tx_nxt        = 1'b1;
    rd_en_nxt     = 1'b0;
    byte_done_nxt = 1'b0;
    busy_nxt      = (state_nxt != S_IDLE);

    case (state_nxt)
      S_FETCH: rd_en_nxt = 1'b1;
      S_START: tx_nxt    = 1'b0;
      S_DATA:  tx_nxt    = shift_nxt[0];
      S_STOP:  byte_done_nxt = (baud_nxt == BAUD_LAST) && (bit_nxt == STOP_LAST);
      default: tx_nxt    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk;
  logic rst;

  // DUT 1: STOP_BITS = 1
  logic       empty1;
  logic [7:0] data1;
  logic       rd_en1;
  logic       tx_en1;
  logic       tx1;
  logic       busy1;
  logic       bd1;

  // DUT 2: STOP_BITS = 2
  logic       empty2;
  logic [7:0] data2;
  logic       rd_en2;
  logic       tx_en2;
  logic       tx2;
  logic       busy2;
  logic       bd2;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .fifo_empty(empty1), .fifo_data(data1),
    .fifo_rd_en(rd_en1), .tx_enable(tx_en1), .tx(tx1), .busy(busy1),
    .byte_done(bd1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_empty(empty2), .fifo_data(data2),
    .fifo_rd_en(rd_en2), .tx_enable(tx_en2), .tx(tx2), .busy(busy2),
    .byte_done(bd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // FIFO model for DUT 1: registered data_out, random garbage otherwise
  logic [7:0] mem1 [0:15];
  int wr_ptr1 = 0;
  int rd_ptr1 = 0;
  logic [7:0] sb_q [$];

  assign empty1 = (wr_ptr1 == rd_ptr1);

  always @(posedge clk) begin
    if (rd_en1 && (wr_ptr1 != rd_ptr1)) begin
      data1   <= mem1[rd_ptr1 % 16];
      rd_ptr1 <= rd_ptr1 + 1;
    end else begin
      data1 <= 8'($urandom);
    end
  end

  task automatic push1(input logic [7:0] b);
    mem1[wr_ptr1 % 16] = b;
    wr_ptr1 = wr_ptr1 + 1;
    sb_q.push_back(b);
  endtask

  // One-deep FIFO model for DUT 2
  logic [7:0] hold2;
  int wr2 = 0;
  int rd2 = 0;
  assign empty2 = (wr2 == rd2);

  always @(posedge clk) begin
    if (rd_en2 && (wr2 != rd2)) begin
      data2 <= hold2;
      rd2   <= rd2 + 1;
    end else begin
      data2 <= 8'($urandom);
    end
  end

  // Event counters for DUT 1
  int cyc = 0;
  int rd_cnt = 0;
  int bd_cnt = 0;
  int rd_double = 0;
  int empty_rd = 0;
  int last_rd_cyc = 0;
  logic prev_rd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_rd <= rd_en1;
    if (rd_en1) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
      if (prev_rd) rd_double <= rd_double + 1;
      if (empty1)  empty_rd  <= empty_rd + 1;
    end
    if (bd1) bd_cnt <= bd_cnt + 1;
  end

  // Serial monitor / scoreboard consumer for DUT 1
  int frames = 0;
  int starts [$];

  initial begin : mon
    logic [9:0] bits;
    logic [7:0] exp_b;
    logic       lvl;
    logic       stable;
    logic       bd_ok;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx1 === 1'b0) begin
        chk("rd_to_start_latency", 64'(cyc - last_rd_cyc), 64'd2);
        starts.push_back(cyc);
        exp_b = 8'h00;
        chk("sb_nonempty_at_start", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) exp_b = sb_q.pop_front();
        bits    = '0;
        lvl     = 1'b0;
        stable  = 1'b1;
        bd_ok   = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i != 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (i % CPB == 0) lvl = tx1;
          else if (tx1 !== lvl) stable = 1'b0;
          if (i % CPB == 1) bits[i / CPB] = tx1;
          if (bd1 !== (i == 10 * CPB - 1)) bd_ok = 1'b0;
        end
        if (!aborted) begin
          frames++;
          chk("frame_start_bit", 64'(bits[0]), 64'd0);
          chk("frame_data", 64'(bits[8:1]), 64'(exp_b));
          chk("frame_stop_bit", 64'(bits[9]), 64'd1);
          chk("frame_bit_stable", 64'(stable), 64'd1);
          chk("frame_byte_done_pos", 64'(bd_ok), 64'd1);
        end
      end
    end
  end

  task automatic wait_busy(input logic val, input int max, input string tag);
    int n;
    n = 0;
    while (busy1 !== val && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(busy1), 64'(val));
  endtask

  task automatic wait_tx_low(input int max, input string tag);
    int n;
    n = 0;
    while (tx1 !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(tx1), 64'd0);
  endtask

  initial begin : stim
    int rd0;
    int bd0;
    int f0;
    int s0;
    int n;
    int viol;
    logic [7:0]  b6;
    logic [43:0] got_tx;
    logic [43:0] exp_tx;
    logic [43:0] got_bd;
    logic [43:0] exp_bd;

    rst    = 1'b0;
    tx_en1 = 1'b0;
    tx_en2 = 1'b0;
    hold2  = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx", 64'(tx1), 64'd1);
    chk("rst_rd_en", 64'(rd_en1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_byte_done", 64'(bd1), 64'd0);
    chk("rst_tx2", 64'(tx2), 64'd1);
    rst = 1'b0;

    // 1: enabled but FIFO empty for 100 cycles
    tx_en1 = 1'b1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || rd_en1 !== 1'b0 || busy1 !== 1'b0) viol++;
    end
    chk("s1_idle_violations", 64'(viol), 64'd0);

    // 2: single byte 0xA5
    rd0 = rd_cnt; bd0 = bd_cnt; f0 = frames;
    push1(8'hA5);
    wait_busy(1'b1, 10, "s2_busy_rise");
    wait_busy(1'b0, 100, "s2_busy_fall");
    repeat (3) @(negedge clk);
    chk("s2_rd_pulses", 64'(rd_cnt - rd0), 64'd1);
    chk("s2_byte_done_pulses", 64'(bd_cnt - bd0), 64'd1);
    chk("s2_frames", 64'(frames - f0), 64'd1);
    chk("s2_tx_idle", 64'(tx1), 64'd1);

    // 3: three queued bytes back-to-back
    tx_en1 = 1'b0;
    @(negedge clk);
    rd0 = rd_cnt; f0 = frames; s0 = starts.size();
    push1(8'h00); push1(8'hFF); push1(8'h3C);
    @(negedge clk);
    tx_en1 = 1'b1;
    wait_busy(1'b1, 10, "s3_busy_rise");
    n = 0;
    while (busy1 === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("s3_busy_span", 64'(n), 64'd126);
    repeat (2) @(negedge clk);
    chk("s3_rd_pulses", 64'(rd_cnt - rd0), 64'd3);
    chk("s3_frames", 64'(frames - f0), 64'd3);
    chk("s3_start_count", 64'(starts.size() - s0), 64'd3);
    if (starts.size() - s0 == 3) begin
      chk("s3_period_1_2", 64'(starts[s0 + 1] - starts[s0]), 64'd42);
      chk("s3_period_2_3", 64'(starts[s0 + 2] - starts[s0 + 1]), 64'd42);
    end

    // 4: drop tx_enable in the middle of the first of two frames
    tx_en1 = 1'b0;
    @(negedge clk);
    rd0 = rd_cnt; f0 = frames;
    push1(8'h11); push1(8'h22);
    tx_en1 = 1'b1;
    wait_tx_low(10, "s4_first_start");
    repeat (12) @(negedge clk);
    tx_en1 = 1'b0;
    wait_busy(1'b0, 100, "s4_first_done");
    repeat (20) @(negedge clk);
    chk("s4_rd_while_disabled", 64'(rd_cnt - rd0), 64'd1);
    chk("s4_idle_busy", 64'(busy1), 64'd0);
    chk("s4_pending", 64'(wr_ptr1 - rd_ptr1), 64'd1);
    tx_en1 = 1'b1;
    wait_busy(1'b1, 10, "s4_resume");
    wait_busy(1'b0, 100, "s4_second_done");
    repeat (2) @(negedge clk);
    chk("s4_rd_total", 64'(rd_cnt - rd0), 64'd2);
    chk("s4_frames", 64'(frames - f0), 64'd2);

    // 5: reset during data bit 3
    rd0 = rd_cnt;
    push1(8'h5A);
    wait_tx_low(10, "s5_start");
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_tx", 64'(tx1), 64'd1);
    chk("s5_rst_busy", 64'(busy1), 64'd0);
    chk("s5_rst_rd_en", 64'(rd_en1), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd0 = rd_cnt;
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0) viol++;
    end
    chk("s5_post_rst_idle", 64'(viol), 64'd0);
    chk("s5_post_rst_rd", 64'(rd_cnt - rd0), 64'd0);

    // 6: two stop bits, byte 0x81
    b6 = 8'h81;
    hold2 = b6;
    wr2 = wr2 + 1;
    tx_en2 = 1'b1;
    n = 0;
    while (tx2 !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s6_start", 64'(tx2), 64'd0);
    for (int i = 0; i < 44; i++) begin
      if (i != 0) @(negedge clk);
      got_tx[i] = tx2;
      got_bd[i] = bd2;
      if (i < 4)       exp_tx[i] = 1'b0;
      else if (i < 36) exp_tx[i] = b6[(i - 4) / 4];
      else             exp_tx[i] = 1'b1;
      exp_bd[i] = (i == 43);
    end
    chk("s6_tx_sequence", 64'(got_tx), 64'(exp_tx));
    chk("s6_byte_done", 64'(got_bd), 64'(exp_bd));
    @(negedge clk);
    chk("s6_end_busy", 64'(busy2), 64'd0);
    chk("s6_end_tx", 64'(tx2), 64'd1);
    chk("s6_reads", 64'(rd2), 64'd1);

    // Global protocol counters
    chk("rd_en_double_cycle", 64'(rd_double), 64'd0);
    chk("read_of_empty_fifo", 64'(empty_rd), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
